// File: rtl/ssd1306_display_sequencer_pkg.sv
// ssd1306_pkg: shared definitions for the SSD1306 display sequencer.
//   - FSM state codes and procedure sub-handshake phase codes
//   - default microcode procedure offsets (shared with the microcode ROM)
//   - spi_beat_t: one byte-wide transfer request toward the SPI shift register
package ssd1306_pkg;

  localparam logic [3:0] S_OFF      = 4'd0;
  localparam logic [3:0] S_INIT     = 4'd1;
  localparam logic [3:0] S_ON_IDLE  = 4'd2;
  localparam logic [3:0] S_WINDOW   = 4'd3;
  localparam logic [3:0] S_FETCH    = 4'd4;
  localparam logic [3:0] S_SEND     = 4'd5;
  localparam logic [3:0] S_WAIT     = 4'd6;
  localparam logic [3:0] S_ENDFRAME = 4'd7;
  localparam logic [3:0] S_POWEROFF = 4'd8;

  // Procedure sub-handshake: A = wait idle then start, B = wait busy, C = wait idle again
  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  localparam int DEF_MICROCODE_SIZE  = 48;
  localparam int DEF_INIT_OFFSET     = 0;
  localparam int DEF_WINDOW_OFFSET   = 24;
  localparam int DEF_ENDFRAME_OFFSET = 34;
  localparam int DEF_POWEROFF_OFFSET = 38;
  localparam int DEF_FRAME_BYTES     = 512;

  typedef struct packed {
    logic       trigger;
    logic [7:0] data;
    logic       last;
  } spi_beat_t;

  // States that run a microcode procedure through the executor
  function automatic logic is_proc_state(input logic [3:0] s);
    return (s == S_INIT) || (s == S_WINDOW) || (s == S_ENDFRAME) || (s == S_POWEROFF);
  endfunction

endpackage

// File: rtl/ssd1306_display_sequencer_if.sv
// ssd1306_spi_if: link between the sequencer and the SPI shift register.
//   spi_tx_trigger_out : start shifting spi_data_out
//   spi_data_out       : byte to shift
//   spi_last_byte_out  : byte closes the current transfer
//   spi_ready_in       : shift register idle / able to accept a byte
// master = sequencer side, slave = shift-register side.
interface ssd1306_spi_if;
  logic       spi_tx_trigger_out;
  logic [7:0] spi_data_out;
  logic       spi_last_byte_out;
  logic       spi_ready_in;

  modport master (output spi_tx_trigger_out, spi_data_out, spi_last_byte_out,
                  input  spi_ready_in);
  modport slave  (input  spi_tx_trigger_out, spi_data_out, spi_last_byte_out,
                  output spi_ready_in);
endinterface

// File: rtl/ssd1306_display_sequencer_spi_mux.sv
// ssd1306_spi_mux: combinational owner select for the shared SPI shift register.
//   owner_pix : 1 = pixel streamer owns the shift register, 0 = microcode executor
//   mc_beat   : executor request      pix_beat : pixel streamer request
//   spi_ready : shift-register ready  spi_beat : request forwarded to the shift register
//   mc_ready  : ready returned to the executor; held low while it does not own the bus,
//               so the executor stalls instead of pushing bytes into the pixel stream
module ssd1306_spi_mux
  import ssd1306_pkg::*;
(
  input  logic      owner_pix,
  input  spi_beat_t mc_beat,
  input  spi_beat_t pix_beat,
  input  logic      spi_ready,
  output spi_beat_t spi_beat,
  output logic      mc_ready
);

  always_comb begin
    if (owner_pix) begin
      spi_beat = pix_beat;
      mc_ready = 1'b0;
    end else begin
      spi_beat = mc_beat;
      mc_ready = spi_ready;
    end
  end

endmodule

// File: rtl/ssd1306_display_sequencer.sv
// ssd1306_display_sequencer: schedules SSD1306 microcode procedures (init, window,
// end-of-frame, power-off) and streams one frame from a synchronous frame-buffer RAM
// through the shared SPI shift register between them.
//   clk_in / rstn_in            : clock, synchronous active-low reset
//   power_on/off_req_in,
//   frame_req_in                : one-cycle application requests
//   display_on_out, busy_out,
//   frame_done_out              : status
//   procedure_*                 : microcode executor start/offset/done handshake
//   mc_spi_*                    : executor's SPI request and gated ready
//   pix_addr_out / pix_data_in  : frame-buffer read port (1-cycle latency)
//   spi                         : SPI shift-register link
module ssd1306_display_sequencer
  import ssd1306_pkg::*;
#(
  parameter int MICROCODE_SIZE  = DEF_MICROCODE_SIZE,
  parameter int INIT_OFFSET     = DEF_INIT_OFFSET,
  parameter int WINDOW_OFFSET   = DEF_WINDOW_OFFSET,
  parameter int ENDFRAME_OFFSET = DEF_ENDFRAME_OFFSET,
  parameter int POWEROFF_OFFSET = DEF_POWEROFF_OFFSET,
  parameter int FRAME_BYTES     = DEF_FRAME_BYTES,
  localparam int OW = $clog2(MICROCODE_SIZE),
  localparam int AW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1
) (
  input  logic          clk_in,
  input  logic          rstn_in,
  input  logic          power_on_req_in,
  input  logic          power_off_req_in,
  input  logic          frame_req_in,
  output logic          display_on_out,
  output logic          busy_out,
  output logic          frame_done_out,
  output logic [OW-1:0] procedure_offset_out,
  output logic          procedure_start_out,
  input  logic          procedure_done_in,
  input  logic          mc_spi_tx_trigger_in,
  input  logic [7:0]    mc_spi_data_in,
  input  logic          mc_spi_last_byte_in,
  output logic          mc_spi_ready_out,
  output logic [AW-1:0] pix_addr_out,
  input  logic [7:0]    pix_data_in,
  ssd1306_spi_if.master spi
);

  localparam logic [OW-1:0] INIT_OFF     = OW'(INIT_OFFSET);
  localparam logic [OW-1:0] WINDOW_OFF   = OW'(WINDOW_OFFSET);
  localparam logic [OW-1:0] ENDFRAME_OFF = OW'(ENDFRAME_OFFSET);
  localparam logic [OW-1:0] POWEROFF_OFF = OW'(POWEROFF_OFFSET);
  localparam logic [AW-1:0] LAST_ADDR    = AW'(FRAME_BYTES - 1);

  logic [3:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          pend_on_q, pend_on_d;
  logic          pend_frame_q, pend_frame_d;
  logic          pend_off_q, pend_off_d;
  logic          display_on_q, display_on_d;
  logic          frame_done_q, frame_done_d;

  logic          spi_ready;
  logic          in_proc, proc_start, proc_fin, exit_ok;
  logic          addr_last, owner_pix, req_open;
  spi_beat_t     mc_beat, pix_beat, out_beat;

  assign spi_ready = spi.spi_ready_in;
  assign in_proc   = is_proc_state(state_q);
  assign addr_last = (addr_q == LAST_ADDR);
  assign owner_pix = (state_q == S_FETCH) || (state_q == S_SEND) || (state_q == S_WAIT);
  assign req_open  = (state_q != S_OFF) && (state_q != S_INIT);

  // Leaving WINDOW hands the bus to the pixel streamer; only do it while the shift
  // register is idle and the executor is not mid-trigger so no byte is torn.
  assign exit_ok = (state_q != S_WINDOW) || (spi_ready && !mc_spi_tx_trigger_in);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    pend_on_d    = pend_on_q;
    pend_frame_d = pend_frame_q;
    pend_off_d   = pend_off_q;
    display_on_d = display_on_q;
    frame_done_d = 1'b0;
    proc_start   = 1'b0;
    proc_fin     = 1'b0;

    if (power_on_req_in && (state_q == S_OFF)) pend_on_d    = 1'b1;
    if (frame_req_in && req_open)              pend_frame_d = 1'b1;
    if (power_off_req_in && req_open)          pend_off_d   = 1'b1;

    if (in_proc) begin
      case (phase_q)
        PH_A: if (procedure_done_in && spi_ready) begin
          proc_start = 1'b1;
          phase_d    = PH_B;
        end
        PH_B: if (!procedure_done_in) phase_d = PH_C;
        default: if (procedure_done_in && exit_ok) begin
          proc_fin = 1'b1;
          phase_d  = PH_A;
        end
      endcase
    end

    case (state_q)
      S_OFF: if (pend_on_q) begin
        state_d   = S_INIT;
        pend_on_d = 1'b0;
      end
      S_INIT: if (proc_fin) begin
        state_d      = S_ON_IDLE;
        display_on_d = 1'b1;
      end
      S_ON_IDLE: begin
        if (pend_off_q) begin
          state_d    = S_POWEROFF;
          pend_off_d = 1'b0;
        end else if (pend_frame_q) begin
          state_d      = S_WINDOW;
          // a request landing on the acceptance cycle queues the next frame
          pend_frame_d = frame_req_in;
        end
      end
      S_WINDOW: if (proc_fin) begin
        state_d = S_FETCH;
        addr_d  = '0;
      end
      S_FETCH: state_d = S_SEND;
      S_SEND:  if (!spi_ready) state_d = S_WAIT;
      S_WAIT: if (spi_ready) begin
        if (addr_last) begin
          state_d = S_ENDFRAME;
        end else begin
          state_d = S_FETCH;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_ENDFRAME: if (proc_fin) begin
        state_d      = S_ON_IDLE;
        frame_done_d = 1'b1;
      end
      S_POWEROFF: if (proc_fin) begin
        state_d      = S_OFF;
        display_on_d = 1'b0;
        pend_frame_d = 1'b0;
        pend_off_d   = 1'b0;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_q      <= S_OFF;
      phase_q      <= PH_A;
      addr_q       <= '0;
      pend_on_q    <= 1'b0;
      pend_frame_q <= 1'b0;
      pend_off_q   <= 1'b0;
      display_on_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      pend_on_q    <= pend_on_d;
      pend_frame_q <= pend_frame_d;
      pend_off_q   <= pend_off_d;
      display_on_q <= display_on_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    case (state_q)
      S_WINDOW:   procedure_offset_out = WINDOW_OFF;
      S_ENDFRAME: procedure_offset_out = ENDFRAME_OFF;
      S_POWEROFF: procedure_offset_out = POWEROFF_OFF;
      default:    procedure_offset_out = INIT_OFF;
    endcase
  end

  assign procedure_start_out = proc_start;
  assign display_on_out      = display_on_q;
  assign frame_done_out      = frame_done_q;
  assign busy_out            = (state_q != S_OFF) && (state_q != S_ON_IDLE);
  assign pix_addr_out        = addr_q;

  assign mc_beat  = '{trigger: mc_spi_tx_trigger_in, data: mc_spi_data_in, last: mc_spi_last_byte_in};
  assign pix_beat = '{trigger: (state_q == S_SEND), data: pix_data_in,
                      last: (state_q == S_SEND) && addr_last};

  ssd1306_spi_mux u_mux (
    .owner_pix (owner_pix),
    .mc_beat   (mc_beat),
    .pix_beat  (pix_beat),
    .spi_ready (spi_ready),
    .spi_beat  (out_beat),
    .mc_ready  (mc_spi_ready_out)
  );

  assign spi.spi_tx_trigger_out = out_beat.trigger;
  assign spi.spi_data_out       = out_beat.data;
  assign spi.spi_last_byte_out  = out_beat.last;

endmodule
